// File: rtl/game_pkg.sv
// Shared definitions for the button front end: debounce FSM states and
// the default debounce window (10 ms at 50 MHz).
package game_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      PRESSED,
      RELEASE_WAIT
   } db_state_t;

   localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

endpackage

// File: rtl/btn_debounce_ch.sv
// One debounce channel: 2-flop synchronizer, four-state accept FSM with a
// stability counter, and registered level / press / release outputs.
module btn_debounce_ch
   import game_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic press,
   output logic rel
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1, s;
   db_state_t        state, next_state;
   logic [CNT_W-1:0] cnt, cnt_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b0;
         s     <= 1'b0;
         state <= IDLE;
         cnt   <= '0;
         level <= 1'b0;
         press <= 1'b0;
         rel   <= 1'b0;
      end else begin
         sync1 <= raw;
         s     <= sync1;
         state <= next_state;
         cnt   <= cnt_next;
         // Outputs follow the next state so they rise with the accepting edge.
         level <= (next_state == PRESSED) || (next_state == RELEASE_WAIT);
         press <= (state == PRESS_WAIT) && (next_state == PRESSED);
         rel   <= (state == RELEASE_WAIT) && (next_state == IDLE);
      end
   end

   // Counter is compared before incrementing and zeroed on every transition.
   always_comb begin
      next_state = state;
      cnt_next   = cnt;
      case (state)
         IDLE: begin
            if (s) begin
               next_state = PRESS_WAIT;
               cnt_next   = '0;
            end
         end
         PRESS_WAIT: begin
            if (!s) begin
               next_state = IDLE;
               cnt_next   = '0;
            end else if (cnt == LAST) begin
               next_state = PRESSED;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         PRESSED: begin
            if (!s) begin
               next_state = RELEASE_WAIT;
               cnt_next   = '0;
            end
         end
         RELEASE_WAIT: begin
            if (s) begin
               next_state = PRESSED;
               cnt_next   = '0;
            end else if (cnt == LAST) begin
               next_state = IDLE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         default: begin
            next_state = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

endmodule

// File: rtl/btn_debounce.sv
// Multi-channel push-button debouncer; each channel is independent and
// any_press is a plain OR of the registered press pulses.
module btn_debounce
   import game_pkg::*;
#(
   parameter int NUM_BTN         = 5,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_BTN-1:0] btn_raw,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] btn_press,
   output logic [NUM_BTN-1:0] btn_release,
   output logic               any_press
);

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
      btn_debounce_ch #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_ch (
         .clk  (clk),
         .rst  (rst),
         .raw  (btn_raw[i]),
         .level(btn_level[i]),
         .press(btn_press[i]),
         .rel  (btn_release[i])
      );
   end

   assign any_press = |btn_press;

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: run-length reference model feeding a scoreboard,
// directed scenarios for latency, bounce, glitch, simultaneous and reset.
module tb_btn_debounce;

   localparam int NB = 5;
   localparam int DC = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NB-1:0] btn_raw = '0;
   logic [NB-1:0] btn_level, btn_press, btn_release;
   logic          any_press;

   always #5 clk = ~clk;

   btn_debounce #(.NUM_BTN(NB), .DEBOUNCE_CYCLES(DC)) dut (
      .clk        (clk),
      .rst        (rst),
      .btn_raw    (btn_raw),
      .btn_level  (btn_level),
      .btn_press  (btn_press),
      .btn_release(btn_release),
      .any_press  (any_press)
   );

   typedef struct packed {
      logic [NB-1:0] lvl;
      logic [NB-1:0] prs;
      logic [NB-1:0] rel;
      logic          any;
   } exp_t;

   exp_t sbq[$];
   int   vectors     = 0;
   int   miscompares = 0;

   // Reference: a level change is accepted once the synchronized input has
   // disagreed with the accepted level for DC+1 consecutive edges.
   logic [NB-1:0] m_q1 = '0, m_q2 = '0, m_lvl = '0;
   int            m_run[NB] = '{default: 0};

   initial begin
      exp_t e;
      logic [NB-1:0] s;
      forever begin
         @(posedge clk);
         e = '0;
         if (rst) begin
            m_q1 = '0;
            m_q2 = '0;
            m_lvl = '0;
            for (int c = 0; c < NB; c++) m_run[c] = 0;
         end else begin
            s    = m_q2;
            m_q2 = m_q1;
            m_q1 = btn_raw;
            for (int c = 0; c < NB; c++) begin
               if (s[c] != m_lvl[c]) begin
                  m_run[c]++;
                  if (m_run[c] == DC + 1) begin
                     m_lvl[c] = s[c];
                     m_run[c] = 0;
                     if (s[c]) e.prs[c] = 1'b1;
                     else      e.rel[c] = 1'b1;
                  end
               end else begin
                  m_run[c] = 0;
               end
            end
         end
         e.lvl = m_lvl;
         e.any = |e.prs;
         sbq.push_back(e);
      end
   end

   initial begin
      exp_t e, a;
      forever begin
         @(posedge clk);
         #1;
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            a = '{btn_level, btn_press, btn_release, any_press};
            vectors++;
            if (a !== e) begin
               miscompares++;
               $display("FAIL scoreboard t=%0t got lvl=%b prs=%b rel=%b any=%b want lvl=%b prs=%b rel=%b any=%b",
                        $time, a.lvl, a.prs, a.rel, a.any, e.lvl, e.prs, e.rel, e.any);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Counts posedges until the chosen pulse appears on channel ch (bounded).
   task automatic wait_pulse(input string nm, input int ch, input bit is_rel, input int exp_edges);
      int n = 0;
      for (int i = 1; i <= 30 && n == 0; i++) begin
         @(posedge clk);
         #1;
         if (is_rel ? btn_release[ch] : btn_press[ch]) n = i;
      end
      chk(nm, n, exp_edges);
      if (!is_rel) chk({nm, "_any"}, any_press, 1);
   endtask

   initial begin
      logic [NB-1:0] bounce;
      int            cnt;
      bit            hi_rate;

      repeat (3) @(negedge clk);
      #1 chk("reset_outputs", {btn_level, btn_press, btn_release, any_press}, 0);
      @(negedge clk);
      rst = 1'b0;

      // Clean press and release on channel 0: pulse after edge DC+2.
      @(negedge clk);
      btn_raw[0] = 1'b1;
      wait_pulse("press0_lat", 0, 0, DC + 3);
      chk("press0_level", btn_level[0], 1);
      @(posedge clk); #1 chk("press0_one_cycle", btn_press[0], 0);
      repeat (5) @(negedge clk);
      btn_raw[0] = 1'b0;
      wait_pulse("rel0_lat", 0, 1, DC + 3);
      chk("rel0_level", btn_level[0], 0);

      // Bounce on channel 1, then a single accepted press.
      bounce = 5'b0;
      foreach (bounce[i]) bounce[i] = 1'b0;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         btn_raw[1] = (i == 2 || i == 6) ? 1'b0 : 1'b1;
      end
      @(negedge clk);
      btn_raw[1] = 1'b1;
      wait_pulse("bounce1_lat", 1, 0, DC + 3);
      repeat (3) @(negedge clk);
      btn_raw[1] = 1'b0;
      repeat (12) @(negedge clk);

      // Release glitch on channel 2.
      btn_raw[2] = 1'b1;
      wait_pulse("press2_lat", 2, 0, DC + 3);
      repeat (4) @(negedge clk);
      btn_raw[2] = 1'b0;
      repeat (2) @(negedge clk);
      btn_raw[2] = 1'b1;
      cnt = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk);
         #1 if (btn_release[2]) cnt++;
      end
      chk("glitch2_no_release", cnt, 0);
      chk("glitch2_level", btn_level[2], 1);
      @(negedge clk);
      btn_raw[2] = 1'b0;
      wait_pulse("rel2_lat", 2, 1, DC + 3);
      repeat (12) @(negedge clk);

      // All channels together, then a long hold.
      btn_raw = '1;
      cnt = 0;
      for (int i = 0; i < 30 && cnt == 0; i++) begin
         @(posedge clk);
         #1 if (btn_press != 0) cnt = 1;
      end
      chk("simul_press", btn_press, 5'b11111);
      cnt = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1 if (btn_press != 0) cnt++;
      end
      chk("hold_no_repress", cnt, 0);
      @(negedge clk);
      btn_raw = '0;
      repeat (12) @(negedge clk);

      // Async reset while channel 3 debounces and channel 4 is pressed.
      btn_raw[4] = 1'b1;
      wait_pulse("press4_lat", 4, 0, DC + 3);
      @(negedge clk);
      btn_raw[3] = 1'b1;
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      #1 chk("async_reset_out", {btn_level, btn_press, btn_release, any_press}, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      wait_pulse("press3_after_rst", 3, 0, DC + 3);
      repeat (3) @(negedge clk);
      btn_raw = '0;
      repeat (12) @(negedge clk);

      // Random traffic: alternate calm and heavily bouncing blocks.
      for (int blk = 0; blk < 16; blk++) begin
         hi_rate = $urandom_range(0, 1);
         for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            for (int c = 0; c < NB; c++)
               if ($urandom_range(0, hi_rate ? 2 : 19) == 0) btn_raw[c] = ~btn_raw[c];
         end
      end
      @(negedge clk);
      btn_raw = '0;
      repeat (20) @(negedge clk);
      for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clk);
      #2;
      chk("sb_drained", sbq.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 Parameter NUM_BTN, default 5; number of independent push-button channels (bit 0 = start button, bits 1..4 = mole buttons).
REQ-002 Parameter DEBOUNCE_CYCLES, default 500000 (10 ms at 50 MHz); consecutive stable cycles required to accept a level change; legal range 2..2^24.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 btn_raw  input  NUM_BTN  raw, asynchronous, bouncing button levels; 1 = pressed.
REQ-006 btn_level  output  NUM_BTN  debounced level per channel.
REQ-007 btn_press  output  NUM_BTN  one-cycle pulse per channel on an accepted press; bit 0 drives the game FSM start_btn input.
REQ-008 btn_release  output  NUM_BTN  one-cycle pulse per channel on an accepted release.
REQ-009 any_press  output  1  OR of btn_press, same cycle.

Function
REQ-010 Each channel SHALL pass btn_raw through a 2-flop synchronizer; its second-stage output is "s".
REQ-011 Each channel SHALL run an FSM with states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT and a counter of width $clog2(DEBOUNCE_CYCLES).
REQ-012 IDLE: s==1 -> PRESS_WAIT with counter cleared to 0; otherwise stay.
REQ-013 PRESS_WAIT: s==0 -> IDLE (bounce rejected, no pulse); s==1 and counter==DEBOUNCE_CYCLES-1 -> PRESSED; otherwise increment the counter.
REQ-014 PRESSED: s==0 -> RELEASE_WAIT with counter cleared to 0; otherwise stay.
REQ-015 RELEASE_WAIT: s==1 -> PRESSED (no pulse); s==0 and counter==DEBOUNCE_CYCLES-1 -> IDLE; otherwise increment the counter.
REQ-016 btn_level SHALL be registered and equal 1 exactly in PRESSED and RELEASE_WAIT.
REQ-017 btn_press SHALL be registered and high for exactly the one cycle after the PRESS_WAIT->PRESSED transition, coincident with btn_level rising.
REQ-018 btn_release SHALL be registered and high for exactly the one cycle after the RELEASE_WAIT->IDLE transition, coincident with btn_level falling.
REQ-019 Latency: raw held high from sampling edge 0 -> btn_level/btn_press high after edge DEBOUNCE_CYCLES+2; release is symmetric.
REQ-020 The counter SHALL never wrap; it is compared before incrementing and cleared on every state entry.
REQ-021 Channels SHALL be fully independent; simultaneous presses on several channels SHALL produce simultaneous pulses.
REQ-022 A held button SHALL produce no further press pulses until it has been released and accepted.

Reset
REQ-023 While rst is high: synchronizers 0, all FSMs IDLE, counters 0, btn_level/btn_press/btn_release/any_press 0.
REQ-024 Reset asserted mid-debounce or mid-press SHALL abort with no pulse. After deassertion, a button still held SHALL be re-debounced from IDLE and yield one press pulse.

Structure
REQ-025 The shared package game_pkg SHALL hold the debounce state enum (IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT) and the DEBOUNCE_CYCLES default constant.
REQ-026 One sub-module btn_debounce_ch (synchronizer, FSM, counter, pulse registers for one channel) SHALL be instantiated NUM_BTN times via generate.
REQ-027 any_press SHALL be a registered OR or a combinational OR of the registered pulses; it SHALL contain no independent state.

Verification (DEBOUNCE_CYCLES=4, NUM_BTN=5)
REQ-028 Clean press: btn_raw[0] goes 0->1 and is held -> btn_level[0] and btn_press[0] rise after edge 6; btn_press[0] is high for 1 cycle; any_press=1 in the same cycle.
REQ-029 Bounce: btn_raw[1] pattern 1,1,0,1,1,1,0 (one value per cycle), then held 1 -> no pulse during the pattern; exactly one btn_press[1], 6 edges after the final rise.
REQ-030 Release glitch: channel 2 pressed, then raw 0 for 2 cycles and back to 1 -> btn_level[2] stays 1 with no btn_release[2]; a sustained 0 -> btn_release[2] 6 edges later.
REQ-031 Simultaneous: btn_raw=5'b11111 from all-idle -> btn_press=5'b11111 in a single cycle; holding for 100 cycles -> no further pulses.
REQ-032 Reset mid-operation: rst asserted asynchronously between clock edges while channel 3 is in PRESS_WAIT -> all outputs are 0 immediately; after release with raw still 1 -> one btn_press[3] 6 edges after rst falls.
